uart_mmio_bridge: RTL and testbench

//  Memory-mapped bridge between the MIPS150 data-memory port and the UART ready/valid byte

---
 rtl/uart_mmio_bridge.sv | 144 ++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped bridge between the CPU data port and a UART byte interface:
// RX/TX byte FIFOs, TX overflow flag and a free-running cycle counter.
module uart_mmio_bridge #(
  parameter int          RX_DEPTH = 8,
  parameter int          TX_DEPTH = 8,
  parameter logic [3:0]  BASE     = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  localparam int RXPW = $clog2(RX_DEPTH);
  localparam int RXCW = RXPW + 1;
  localparam int TXPW = $clog2(TX_DEPTH);
  localparam int TXCW = TXPW + 1;
  localparam logic [RXCW-1:0] RX_FULL = RXCW'(RX_DEPTH);
  localparam logic [TXCW-1:0] TX_FULL = TXCW'(TX_DEPTH);

  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RXPW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RXCW-1:0] rx_count;
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TXPW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TXCW-1:0] tx_count;
  logic            tx_ovf;
  logic [31:0]     cyc_cnt;
  logic [31:0]     rd_mux;
  logic [31:0]     rd_data_p1;

  logic       sel, cpu_en, cpu_rd, cpu_wr;
  logic [2:0] off;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic       tx_ovf_set, tx_ovf_clr, cnt_clr;
  logic [7:0] rx_head;

  // Address bits outside the decoded fields and the upper write byte lanes are don't-care.
  logic unused_ok;
  assign unused_ok = ^{addr[27:5], addr[1:0], din[31:8]};

  assign sel    = (addr[31:28] == BASE);
  assign off    = addr[4:2];
  assign cpu_en = sel && !stall;
  assign cpu_rd = cpu_en && re;
  assign cpu_wr = cpu_en && (we != 4'b0000);

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL);
  assign rx_head  = rx_mem[rx_rd_ptr];

  // Ready comes from the registered count only, so a full FIFO never accepts in the pop cycle.
  assign uart_rx_ready = !rst && !rx_full;
  assign uart_tx_valid = !rst && !tx_empty;
  assign uart_tx_data  = tx_mem[tx_rd_ptr];

  assign rx_push    = uart_rx_valid && uart_rx_ready;
  assign rx_pop     = !rst && cpu_rd && (off == 3'd1) && !rx_empty;
  assign tx_push    = !rst && cpu_wr && (off == 3'd3) && !tx_full;
  assign tx_pop     = uart_tx_valid && uart_tx_ready;
  assign tx_ovf_set = cpu_wr && (off == 3'd3) && tx_full;
  assign tx_ovf_clr = cpu_wr && (off == 3'd2);
  assign cnt_clr    = cpu_wr && (off == 3'd4);

  always_comb begin
    rd_mux = '0;
    unique case (off)
      3'd0:    rd_mux = {31'b0, !rx_empty};
      3'd1:    rd_mux = rx_empty ? 32'h0 : {24'b0, rx_head};
      3'd2:    rd_mux = {30'b0, tx_ovf, !tx_full};
      3'd4:    rd_mux = cyc_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= din[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RXPW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RXPW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RXCW'(1);
        2'b01:   rx_count <= rx_count - RXCW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_ovf    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TXPW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TXPW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TXCW'(1);
        2'b01:   tx_count <= tx_count - TXCW'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_ovf_clr)      tx_ovf <= 1'b0;
      else if (tx_ovf_set) tx_ovf <= 1'b1;
    end
  end

  // Counter runs through stalls; a clearing write wins over the increment.
  always_ff @(posedge clk) begin
    if (rst)          cyc_cnt <= '0;
    else if (cnt_clr) cyc_cnt <= '0;
    else              cyc_cnt <= cyc_cnt + 32'd1;
  end

  // Stage p1: registered read data, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst)         rd_data_p1 <= '0;
    else if (!stall) rd_data_p1 <= (sel && re) ? rd_mux : 32'h0;
  end

  assign dout = rd_data_p1;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: vector table for basic register
// traffic, hand-written sequences for FIFO limits, stall and reset.
module tb_uart_mmio_bridge;

  localparam logic [3:0] BASE_SEL = 4'h8;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  uart_mmio_bridge #(.RX_DEPTH(8), .TX_DEPTH(8), .BASE(BASE_SEL)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .addr          (addr),
    .re            (re),
    .we            (we),
    .din           (din),
    .dout          (dout),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  seen_q [$];

  // Capture every byte the UART side accepts; the transfer lands on the next rising edge.
  always @(negedge clk) begin
    if (uart_tx_valid && uart_tx_ready) seen_q.push_back(uart_tx_data);
  end

  typedef struct {
    logic [1:0]  kind;   // 0 read, 1 write, 2 UART delivers byte
    logic [2:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input logic [2:0] off, input logic [1:0] lo);
    return {BASE_SEL, 23'h0, off, lo};
  endfunction

  task automatic cpu_rd(input logic [2:0] off, input logic [31:0] exp, input string nm);
    addr = reg_addr(off, 2'b00);
    re   = 1'b1;
    we   = 4'b0000;
    exp_q.push_back(exp);
    cyc();
    re = 1'b0;
    chk(nm, dout, exp_q.pop_front());
  endtask

  task automatic cpu_wr(input logic [2:0] off, input logic [31:0] data, input logic [3:0] bes);
    addr = reg_addr(off, 2'b01);
    we   = bes;
    din  = data;
    cyc();
    we = 4'b0000;
  endtask

  task automatic uart_send(input logic [7:0] b, input string nm);
    logic done;
    done          = 1'b0;
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      if (uart_rx_ready) done = 1'b1;
      cyc();
    end
    uart_rx_valid = 1'b0;
    chk(nm, {31'b0, done}, 32'h1);
  endtask

  task automatic tx_score(input string nm);
    logic [7:0] s;
    while (seen_q.size() != 0) begin
      s = seen_q.pop_front();
      if (tx_q.size() == 0) chk({nm, "_extra"}, {24'b0, s}, 32'hFFFF_FFFF);
      else                  chk(nm, {24'b0, s}, {24'b0, tx_q.pop_front()});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd0, 3'd0, 32'h0,        32'h0};
    vecs[1]  = '{2'd0, 3'd2, 32'h0,        32'h1};
    vecs[2]  = '{2'd0, 3'd5, 32'h0,        32'h0};
    vecs[3]  = '{2'd2, 3'd0, 32'h41,       32'h0};
    vecs[4]  = '{2'd2, 3'd0, 32'h42,       32'h0};
    vecs[5]  = '{2'd0, 3'd0, 32'h0,        32'h1};
    vecs[6]  = '{2'd0, 3'd1, 32'h0,        32'h41};
    vecs[7]  = '{2'd0, 3'd1, 32'h0,        32'h42};
    vecs[8]  = '{2'd0, 3'd0, 32'h0,        32'h0};
    vecs[9]  = '{2'd0, 3'd1, 32'h0,        32'h0};
    vecs[10] = '{2'd1, 3'd5, 32'hFFFF_FFFF, 32'h0};
    vecs[11] = '{2'd0, 3'd3, 32'h0,        32'h0};

    rst = 1'b1; stall = 1'b0; addr = '0; re = 1'b0; we = 4'b0000; din = '0;
    uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk("rst_dout", dout, 32'h0);
    chk("rst_txv", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_rxr", {31'b0, uart_rx_ready}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("rxr_after_rst", {31'b0, uart_rx_ready}, 32'h1);

    // Register traffic table
    for (int i = 0; i < 12; i++) begin
      unique case (vecs[i].kind)
        2'd0:    cpu_rd(vecs[i].off, vecs[i].exp, $sformatf("vec%0d", i));
        2'd1:    cpu_wr(vecs[i].off, vecs[i].data, 4'b1111);
        default: uart_send(vecs[i].data[7:0], $sformatf("vec%0d_send", i));
      endcase
    end
    chk("txv_idle", {31'b0, uart_tx_valid}, 32'h0);

    // TX overflow and drain
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_wr(3'd3, 32'(i), 4'b0001);
      if (i < 8) tx_q.push_back(8'(i));
    end
    chk("tx_full_valid", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_full_head", {24'b0, uart_tx_data}, 32'h0);
    cpu_rd(3'd2, 32'h2, "tx_full_ovf");
    uart_tx_ready = 1'b1;
    for (int c = 0; c < 40 && seen_q.size() < 8; c++) cyc();
    chk("tx_drain_cnt", seen_q.size(), 32'd8);
    tx_score("tx_drain");
    chk("tx_drained_valid", {31'b0, uart_tx_valid}, 32'h0);
    cpu_wr(3'd2, 32'h0, 4'b0100);
    cpu_rd(3'd2, 32'h1, "tx_ovf_clr");
    addr = 32'h1000_0008; re = 1'b1;
    cyc();
    re = 1'b0;
    chk("unsel_read", dout, 32'h0);
    cpu_rd(3'd2, 32'h1, "tx_st2");
    cyc();
    chk("re_low_dout", dout, 32'h0);

    // TX first-byte latency and simultaneous push/pop
    addr = reg_addr(3'd3, 2'b00); we = 4'b0010; din = 32'h5A;
    chk("tx_lat_same", {31'b0, uart_tx_valid}, 32'h0);
    cyc();
    tx_q.push_back(8'h5A);
    chk("tx_lat_next", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_lat_data", {24'b0, uart_tx_data}, 32'h5A);
    din = 32'h5B;
    cyc();
    we = 4'b0000;
    tx_q.push_back(8'h5B);
    chk("tx_pp_valid", {31'b0, uart_tx_valid}, 32'h1);
    chk("tx_pp_data", {24'b0, uart_tx_data}, 32'h5B);
    cyc();
    chk("tx_pp_empty", {31'b0, uart_tx_valid}, 32'h0);
    chk("tx_pp_cnt", seen_q.size(), 32'd2);
    tx_score("tx_pp");

    // RX full, held byte, pop releases ready
    for (int i = 0; i < 8; i++) uart_send(8'(8'h50 + i), "rx_fill");
    chk("rx_full_rdy", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_data = 8'h58; uart_rx_valid = 1'b1;
    cyc();
    chk("rx_hold_rdy", {31'b0, uart_rx_ready}, 32'h0);
    cpu_rd(3'd0, 32'h1, "rx_full_st");
    addr = reg_addr(3'd1, 2'b00); re = 1'b1;
    exp_q.push_back(32'h50);
    chk("rx_pop_same_rdy", {31'b0, uart_rx_ready}, 32'h0);
    cyc();
    re = 1'b0;
    chk("rx_pop", dout, exp_q.pop_front());
    chk("rx_rdy_back", {31'b0, uart_rx_ready}, 32'h1);
    cyc();
    uart_rx_valid = 1'b0;
    chk("rx_refull_rdy", {31'b0, uart_rx_ready}, 32'h0);
    for (int i = 1; i < 9; i++) cpu_rd(3'd1, 32'h50 + 32'(i), $sformatf("rx_order%0d", i));
    cpu_rd(3'd0, 32'h0, "rx_empty_st");

    // Stall freezes CPU effects but not the counter
    uart_send(8'h66, "st_send");
    cpu_wr(3'd4, 32'h0, 4'b1111);
    cpu_rd(3'd0, 32'h1, "st_pre");
    stall = 1'b1; addr = reg_addr(3'd1, 2'b00); re = 1'b1;
    repeat (3) cyc();
    chk("st_rd_hold", dout, 32'h1);
    re = 1'b0; addr = reg_addr(3'd3, 2'b00); we = 4'b0001; din = 32'h77;
    repeat (2) cyc();
    chk("st_wr_hold", dout, 32'h1);
    stall = 1'b0; we = 4'b0000;
    cpu_rd(3'd4, 32'd6, "st_counter");
    cpu_rd(3'd0, 32'h1, "st_no_pop");
    cpu_rd(3'd1, 32'h66, "st_head");
    repeat (3) cyc();
    chk("st_no_push", seen_q.size(), 32'd0);

    // Counter clear and count
    cpu_wr(3'd4, 32'h0, 4'b1000);
    repeat (9) cyc();
    cpu_rd(3'd4, 32'd9, "cnt_after_clr");

    // Reset in the middle of TX traffic
    uart_tx_ready = 1'b0;
    uart_send(8'h99, "rst_rx_send");
    for (int i = 0; i < 9; i++) cpu_wr(3'd3, 32'hA0 + 32'(i), 4'b1000);
    chk("pre_rst_txv", {31'b0, uart_tx_valid}, 32'h1);
    chk("pre_rst_head", {24'b0, uart_tx_data}, 32'hA0);
    cpu_rd(3'd2, 32'h2, "pre_rst_ovf");
    rst = 1'b1;
    cyc();
    chk("mid_rst_txv", {31'b0, uart_tx_valid}, 32'h0);
    chk("mid_rst_rxr", {31'b0, uart_rx_ready}, 32'h0);
    chk("mid_rst_dout", dout, 32'h0);
    cyc();
    rst = 1'b0; uart_tx_ready = 1'b1;
    cpu_rd(3'd4, 32'h0, "post_rst_cnt");
    cpu_rd(3'd0, 32'h0, "post_rst_rx");
    cpu_rd(3'd2, 32'h1, "post_rst_tx");
    chk("post_rst_txv", {31'b0, uart_tx_valid}, 32'h0);
    repeat (3) cyc();
    chk("post_rst_no_tx", seen_q.size(), 32'd0);
    tx_score("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
